// File: rtl/uart_rx_ctrl.sv
// Purpose: UART receive FIFO with a sticky overrun flag, a fill-level interrupt and a character-timeout interrupt.
// Latency: a pop returns rd_data/rd_valid one edge after rd_req; intr is registered one edge after its cause.
// Backpressure: none upstream; a byte arriving while full with no pop in the same cycle is dropped and flags overrun.
module uart_rx_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rd_req,
  input  logic       ovr_clr,
  input  logic [3:0] int_thresh,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [4:0] count,
  output logic       empty,
  output logic       full,
  output logic       overrun,
  output logic       intr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [4:0]    DEPTH_C = 5'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TOUT = 2'd2
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid;
  logic          r_overrun;
  logic          r_intr;
  state_t        r_state;
  logic [CW-1:0] r_idle_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_activity;
  logic [4:0]    w_count_nxt;
  logic [3:0]    w_thr;
  logic          w_intr_nxt;
  state_t        w_state_nxt;
  logic [CW-1:0] w_idle_cnt_nxt;

  assign w_empty = (r_count == 5'd0);
  assign w_full  = (r_count == DEPTH_C);

  // A pop on an empty FIFO is ignored, so a simultaneous push into an empty FIFO never bypasses.
  assign w_pop       = rd_req & ~w_empty;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign w_push      = rx_done & (~w_full | w_pop);
  assign w_drop      = rx_done & w_full & ~w_pop;
  assign w_activity  = w_push | w_pop;
  assign w_count_nxt = r_count + {4'b0, w_push} - {4'b0, w_pop};

  // A threshold of 0 would fire on an empty FIFO, so it behaves as 1.
  assign w_thr      = (int_thresh == 4'd0) ? 4'd1 : int_thresh;
  assign w_intr_nxt = (r_count >= {1'b0, w_thr}) | (r_state == S_TOUT) | r_overrun;

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_rd_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Sticky overrun: a drop in the same cycle as ovr_clr keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  // Timeout FSM state and idle counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  // Timeout next-state: decisions use the post-edge occupancy so an emptying pop lands in IDLE directly.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    if (w_count_nxt == 5'd0) begin
      w_state_nxt    = S_IDLE;
      w_idle_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_WAIT;
          w_idle_cnt_nxt = '0;
        end
        S_WAIT: begin
          if (w_activity) begin
            w_idle_cnt_nxt = '0;
          end else if (r_idle_cnt == CNT_MAX) begin
            w_state_nxt = S_TOUT;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + CW'(1);
          end
        end
        S_TOUT: begin
          // Counter stays saturated until traffic resumes.
          if (w_activity) begin
            w_state_nxt    = S_WAIT;
            w_idle_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_idle_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_intr <= 1'b0;
    end else begin
      r_intr <= w_intr_nxt;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overrun  = r_overrun;
  assign intr     = r_intr;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 Parameter: TIMEOUT, default 32, idle cycles before the character-timeout interrupt.
REQ-003 Port: clk  input  1  system clock; all logic is on the rising edge.
REQ-004 Port: resetn  input  1  asynchronous active-low reset.
REQ-005 Port: rx_data  input  8  received byte from the UART receiver.
REQ-006 Port: rx_done  input  1  one-cycle pulse, rx_data valid.
REQ-007 Port: rd_req  input  1  pop request from the register interface.
REQ-008 Port: ovr_clr  input  1  clears the sticky overrun flag.
REQ-009 Port: int_thresh  input  4  fill level that raises the interrupt; 0 is treated as 1.
REQ-010 Port: rd_data  output  8  popped byte, registered.
REQ-011 Port: rd_valid  output  1  one-cycle strobe, rd_data valid.
REQ-012 Port: count  output  5  current number of entries, 0..DEPTH.
REQ-013 Port: empty / full  output  1 each  count==0 / count==DEPTH.
REQ-014 Port: overrun  output  1  sticky, a byte was dropped.
REQ-015 Port: intr  output  1  level interrupt to the CPU.

Function
REQ-016 Push: rx_done and (not full, or a pop is accepted in the same cycle) writes rx_data at the write pointer; the write pointer advances modulo DEPTH.
REQ-017 Pop: rd_req and not empty reads the head entry; at the next edge rd_data = head and rd_valid = 1 for exactly one cycle; the read pointer advances modulo DEPTH.
REQ-018 rd_req while empty is ignored: rd_valid stays 0, rd_data holds its value, no flags change.
REQ-019 Full with push and pop in the same cycle: both are accepted, count is unchanged, overrun is unchanged.
REQ-020 Empty with push and pop in the same cycle: the push is accepted and the pop is ignored (no bypass); count becomes 1.
REQ-021 Full with rx_done and no pop: the byte is dropped, FIFO contents are unchanged, overrun is set at the next edge.
REQ-022 overrun is cleared only by ovr_clr; if a drop and ovr_clr occur in the same cycle, set wins.
REQ-023 Timeout FSM states:
- IDLE: count==0; idle counter held at 0.
- WAIT: count>0 and no timeout; counter increments each cycle and resets to 0 on any push or accepted pop.
- TOUT: entered when the counter reaches TIMEOUT-1 in WAIT.
REQ-024 TOUT exits to WAIT on push or accepted pop, or to IDLE when count becomes 0; any state goes to IDLE when count==0.
REQ-025 intr = (count >= max(int_thresh,1)) | (state==TOUT) | overrun, registered; it asserts one cycle after the causing event.
REQ-026 The counter saturates in TOUT and does not wrap.

Reset
REQ-027 resetn low asynchronously clears the pointers, count=0, empty=1, full=0, overrun=0, rd_valid=0, rd_data=8'h00, intr=0, and sets the FSM to IDLE; FIFO storage is not cleared.
REQ-028 Reset asserted mid-pop discards the pending rd_valid; the first cycle after deassertion behaves as after power-up.

Verification
REQ-029 Reset, then rx_done with rx_data=8'h07, then rd_req -> count 1 then 0; rd_valid=1 with rd_data=8'h07 one cycle after rd_req.
REQ-030 int_thresh=4, push 8'h01..8'h04 -> intr rises the cycle after the 4th push; pop one byte -> intr falls after the timeout logic clears and TIMEOUT cycles elapse before it re-asserts.
REQ-031 Push 9 bytes (8'h10..8'h18) with DEPTH=8 -> full=1, overrun=1, intr=1; 8 pops return 8'h10..8'h17 in order; ovr_clr -> overrun=0.
REQ-032 Full FIFO, push 8'hAA and pop in the same cycle -> count stays 8, overrun=0; the last of the 8 subsequent pops returns 8'hAA.
REQ-033 int_thresh=8, push 1 byte, then idle -> intr asserts exactly TIMEOUT+1 cycles after the push; a further push deasserts it the next cycle.
REQ-034 rd_req on an empty FIFO, and rd_req with resetn pulsed low for 1 cycle -> rd_valid never asserts; all outputs match REQ-027.
